// File: rtl/mdu_hilo.sv
`timescale 1ns/1ps
// mdu_hilo: E-stage multiply/divide unit owning the HI/LO registers.
// Multi-cycle MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO.
// Optional MADD/MADDU (ops 6/7) enabled by defining MDU_MADD_EN.
module mdu_hilo #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;

`ifdef MDU_MADD_EN
    localparam logic MADD_EN = 1'b1;
`else
    localparam logic MADD_EN = 1'b0;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q;
    logic [31:0]        a_q, b_q;
    logic [63:0]        acc_q;

    logic               accept_c;
    logic               is_mul_c, is_div_c, is_mc_c;
    logic               commit_c;

    logic               sgn_c;
    logic [63:0]        ext_a_c, ext_b_c, prod_c;
    logic               neg_a_c, neg_b_c;
    logic [31:0]        mag_a_c, mag_b_c, quo_c, rem_c;
    logic [63:0]        res_c;
    logic               wr_c;

    assign busy     = (state_q == RUN);
    assign accept_c = start & ~cancel & ~busy;

    // Classify the incoming op as a multi-cycle operation
    always_comb begin
        is_mul_c = (op == OP_MULT) || (op == OP_MULTU) ||
                   (MADD_EN && ((op == OP_MADD) || (op == OP_MADDU)));
        is_div_c = (op == OP_DIV) || (op == OP_DIVU);
        is_mc_c  = is_mul_c | is_div_c;
    end

    // State and countdown registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: load the countdown on accept, commit when it reaches one
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c && is_mc_c) begin
                    state_d = RUN;
                    cnt_d   = is_div_c ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    commit_c = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch operands, op and the accumulator base at accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (accept_c && is_mc_c) begin
            op_q  <= op;
            a_q   <= rs_val;
            b_q   <= rt_val;
            acc_q <= {hi, lo};
        end
    end

    // Result datapath: sign-extended multiply and sign-magnitude divide
    always_comb begin
        sgn_c   = (op_q == OP_MULT) || (op_q == OP_DIV) || (op_q == OP_MADD);
        ext_a_c = sgn_c ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b_c = sgn_c ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod_c  = ext_a_c * ext_b_c;

        neg_a_c = sgn_c & a_q[31];
        neg_b_c = sgn_c & b_q[31];
        mag_a_c = neg_a_c ? (32'd0 - a_q) : a_q;
        mag_b_c = neg_b_c ? (32'd0 - b_q) : b_q;
        quo_c   = (mag_b_c == 32'd0) ? 32'd0 : (mag_a_c / mag_b_c);
        rem_c   = (mag_b_c == 32'd0) ? 32'd0 : (mag_a_c % mag_b_c);
        if (neg_a_c ^ neg_b_c) quo_c = 32'd0 - quo_c;
        if (neg_a_c)           rem_c = 32'd0 - rem_c;

        res_c = prod_c;
        wr_c  = 1'b0;
        case (op_q)
            OP_MULT, OP_MULTU: begin
                res_c = prod_c;
                wr_c  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_c = {rem_c, quo_c};
                wr_c  = (b_q != 32'd0);
            end
            OP_MADD, OP_MADDU: begin
                res_c = acc_q + prod_c;
                wr_c  = MADD_EN;
            end
            default: wr_c = 1'b0;
        endcase
    end

    // HI/LO architectural registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (accept_c && (op == OP_MTHI)) begin
            hi <= rs_val;
        end else if (accept_c && (op == OP_MTLO)) begin
            lo <= rs_val;
        end else if (commit_c && wr_c) begin
            hi <= res_c[63:32];
            lo <= res_c[31:0];
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
`timescale 1ns/1ps
// tb_mdu_hilo: directed and randomized checks of mdu_hilo against a
// behavioural HI/LO model built from plain 64-bit arithmetic.
module tb_mdu_hilo;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic        cancel = 1'b0;
    logic [2:0]  op     = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu_hilo #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Architectural effect of one issued instruction; returns busy length
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic cnc, output int n);
        longint          sa, sb, q, r;
        longint unsigned p;
        n = 0;
        if (cnc) return;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = longint'(sa * sb); {hi_m, lo_m} = 64'(p); n = MULT_N; end
            3'd1: begin p = 64'(a) * 64'(b); {hi_m, lo_m} = 64'(p); n = MULT_N; end
            3'd2: begin
                n = DIV_N;
                if (b != 32'd0) begin
                    q = sa / sb; r = sa % sb;
                    lo_m = q[31:0]; hi_m = r[31:0];
                end
            end
            3'd3: begin
                n = DIV_N;
                if (b != 32'd0) begin lo_m = a / b; hi_m = a % b; end
            end
            3'd4: hi_m = a;
            3'd5: lo_m = a;
`ifdef MDU_MADD_EN
            3'd6: begin p = longint'(sa * sb); {hi_m, lo_m} = {hi_m, lo_m} + 64'(p); n = MULT_N; end
            3'd7: begin p = 64'(a) * 64'(b); {hi_m, lo_m} = {hi_m, lo_m} + 64'(p); n = MULT_N; end
`endif
            default: n = 0;
        endcase
    endtask

    // Issue one instruction; mode 1 = random illegal traffic while busy,
    // mode 2 = cancel pulse then a start+MTLO inside the busy window
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic cnc, input int mode);
        int exp_n, n;
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b; cancel = cnc;
        model(o, a, b, cnc, exp_n);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (mode == 1) begin
                start  = 1'($urandom_range(0, 1));
                op     = 3'($urandom);
                rs_val = $urandom;
                rt_val = $urandom;
                cancel = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                if (n == 2) cancel = 1'b1;
                if (n == 3) begin start = 1'b1; op = 3'd5; rs_val = 32'hDEADBEEF; end
            end
            @(negedge clk);
            start = 1'b0; cancel = 1'b0;
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(exp_n));
        check({tag, " hi"}, 64'(hi), 64'(hi_m));
        check({tag, " lo"}, 64'(lo), 64'(lo_m));
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
        check("mult_neg2x3 hi const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_neg2x3 lo const", 64'(lo), 64'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
        check("multu hi const", 64'(hi), 64'h0000_0002);
        check("multu lo const", 64'(lo), 64'hFFFF_FFFA);
        run_op("div_neg7by2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        check("div_neg7by2 lo const", 64'(lo), 64'hFFFF_FFFD);
        check("div_neg7by2 hi const", 64'(hi), 64'hFFFF_FFFF);
        run_op("div_by0", 3'd2, 32'd1234, 32'd0, 1'b0, 0);
        check("div_by0 lo const", 64'(lo), 64'hFFFF_FFFD);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        check("div_ovf lo const", 64'(lo), 64'h8000_0000);
        check("div_ovf hi const", 64'(hi), 64'd0);
        run_op("mthi_cancel", 3'd4, 32'h1234_5678, 32'd0, 1'b1, 0);
        check("mthi_cancel hi const", 64'(hi), 64'd0);
        run_op("mthi", 3'd4, 32'h1234_5678, 32'd0, 1'b0, 0);
        check("mthi hi const", 64'(hi), 64'h1234_5678);
        run_op("mult_cancel_mtlo", 3'd0, 32'd7, 32'd9, 1'b0, 2);
        check("mult_cancel_mtlo lo const", 64'(lo), 64'd63);

        run_op("mthi0", 3'd4, 32'd0, 32'd0, 1'b0, 0);
        run_op("mtlo_ff", 3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        run_op("maddu", 3'd7, 32'd1, 32'd1, 1'b0, 0);
`ifdef MDU_MADD_EN
        check("maddu hi const", 64'(hi), 64'd1);
        check("maddu lo const", 64'(lo), 64'd0);
`else
        check("maddu hi const", 64'(hi), 64'd0);
        check("maddu lo const", 64'(lo), 64'hFFFF_FFFF);
`endif

        // Reset in the middle of a divide
        run_op("pre_rst_mthi", 3'd4, 32'hA5A5_0001, 32'd0, 1'b0, 0);
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7; cancel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_div busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("rst_mid busy", 64'(busy), 64'd0);
        check("rst_mid hi", 64'(hi), 64'd0);
        check("rst_mid lo", 64'(lo), 64'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst busy", 64'(busy), 64'd0);
        check("post_rst hi", 64'(hi), 64'd0);
        check("post_rst lo", 64'(lo), 64'd0);

        // Randomized traffic, including illegal starts while busy
        for (int i = 0; i < 200; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            logic        cnc;
            int          mode;
            o    = 3'($urandom);
            a    = rnd_operand();
            b    = rnd_operand();
            cnc  = ($urandom_range(0, 5) == 0);
            mode = ($urandom_range(0, 2) == 0) ? 1 : 0;
            run_op($sformatf("rnd%0d_op%0d", i, o), o, a, b, cnc, mode);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
